alu_result_checker: RTL and testbench



---
 rtl/alu_pkg.sv | 71 +++++++
 rtl/alu_ref_model.sv | 23 ++
 rtl/alu_result_checker.sv | 178 +++++++++++++++++
 tb/tb_alu_result_checker.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcodes, checker state encoding, pipe entry type and the
//               8-bit ALU reference function shared by the response checker.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU opcodes
  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_INC   = 4'h2;
  localparam logic [3:0] OP_DEC   = 4'h3;
  localparam logic [3:0] OP_PASSA = 4'h4;
  localparam logic [3:0] OP_ADDC  = 4'h5;
  localparam logic [3:0] OP_AND   = 4'h6;
  localparam logic [3:0] OP_OR    = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_NOTA  = 4'h9;
  localparam logic [3:0] OP_NAND  = 4'hA;
  localparam logic [3:0] OP_NOR   = 4'hB;
  localparam logic [3:0] OP_XNOR  = 4'hC;
  localparam logic [3:0] OP_SHL   = 4'hD;
  localparam logic [3:0] OP_SHR   = 4'hE;
  localparam logic [3:0] OP_PASSB = 4'hF;

  // Checker run states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One in-flight operation waiting for its ALU result
  typedef struct packed {
    logic       vld;
    logic [3:0] sel;
    logic [7:0] exp;
  } pipe_t;

  // Expected 8-bit ALU result; carry-out is dropped, cin only matters for ADDC
  function automatic logic [7:0] alu_ref(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic       cin,
                                         input logic [3:0] sel);
    logic [7:0] r;
    r = 8'h00;
    case (sel)
      OP_ADD:   r = a + b;
      OP_SUB:   r = a - b;
      OP_INC:   r = a + 8'd1;
      OP_DEC:   r = a - 8'd1;
      OP_PASSA: r = a;
      OP_ADDC:  r = a + b + {7'd0, cin};
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOTA:  r = ~a;
      OP_NAND:  r = ~(a & b);
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      OP_SHL:   r = {a[6:0], 1'b0};
      OP_SHR:   r = {1'b0, a[7:1]};
      OP_PASSB: r = b;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : alu_ref_model
// Description : Combinational wrapper around alu_pkg::alu_ref so the same
//               reference can be dropped into other checkers and benches.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ref_model (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  input  logic [3:0] i_sel,
  output logic [7:0] o_y
);
  import alu_pkg::*;

  // Expected result for the operands currently presented
  always_comb begin
    o_y = alu_ref(i_a, i_b, i_cin, i_sel);
  end

endmodule
`default_nettype wire

// File: rtl/alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_checker
// Description : Recomputes each issued ALU operation, delays the expectation
//               by the ALU latency, compares it with Y and keeps saturating
//               pass/fail counts plus a record of the first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_checker #(
  parameter int LATENCY = 1,   // 1..4
  parameter int N_OPS   = 16   // 1..255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ISSUE_VALID,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CIN,
  input  logic [3:0] SEL,
  input  logic [7:0] Y,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] PASS_CNT,
  output logic [7:0] FAIL_CNT,
  output logic       FIRST_FAIL_VALID,
  output logic [3:0] FIRST_FAIL_SEL,
  output logic [7:0] FIRST_FAIL_Y
);
  import alu_pkg::*;

  localparam logic [7:0] c_n_ops   = 8'(N_OPS);
  localparam logic [7:0] c_cnt_max = 8'hFF;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_issued;
  pipe_t      r_pipe [LATENCY];
  pipe_t      w_entry;
  logic [7:0] w_exp;
  logic       w_in_run;
  logic       w_accept;
  logic       w_cmp;
  logic       w_match;
  logic       w_pipe_busy;
  logic       w_all_issued;
  logic [7:0] r_pass_cnt;
  logic [7:0] r_fail_cnt;
  logic       r_ff_valid;
  logic [3:0] r_ff_sel;
  logic [7:0] r_ff_y;

  alu_ref_model u_ref (
    .i_a   (A),
    .i_b   (B),
    .i_cin (CIN),
    .i_sel (SEL),
    .o_y   (w_exp)
  );

  // START has priority: the edge that (re)starts a run neither issues nor compares
  always_comb begin
    w_in_run     = (r_state == alu_pkg::RUN) && !START;
    w_all_issued = (r_issued >= c_n_ops);
    w_accept     = w_in_run && ISSUE_VALID && !w_all_issued;
    w_cmp        = w_in_run && r_pipe[LATENCY-1].vld;
    w_match      = (Y == r_pipe[LATENCY-1].exp);
    w_entry.vld  = w_accept;
    w_entry.sel  = SEL;
    w_entry.exp  = w_exp;
  end

  // Any operation still waiting for its result keeps the run open
  always_comb begin
    w_pipe_busy = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      w_pipe_busy = w_pipe_busy | r_pipe[i].vld;
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= alu_pkg::IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    BUSY        = 1'b0;
    DONE        = 1'b0;
    case (r_state)
      alu_pkg::IDLE: begin
        if (START) w_state_nxt = alu_pkg::RUN;
      end
      alu_pkg::RUN: begin
        BUSY = 1'b1;
        if (START) begin
          w_state_nxt = alu_pkg::RUN;
        end else if (w_all_issued && !w_pipe_busy) begin
          w_state_nxt = alu_pkg::DONE;
        end
      end
      alu_pkg::DONE: begin
        DONE = 1'b1;
        if (START) w_state_nxt = alu_pkg::RUN;
      end
      default: begin
        w_state_nxt = alu_pkg::IDLE;
      end
    endcase
  end

  // Number of operations accepted in this run
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_issued <= 8'd0;
    end else if (START) begin
      r_issued <= 8'd0;
    end else if (w_accept) begin
      r_issued <= r_issued + 8'd1;
    end
  end

  // Expectation delay line; stage LATENCY-1 lines up with the matching Y
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else if (START) begin
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) r_pipe[i] <= r_pipe[i-1];
      r_pipe[0] <= w_entry;
    end
  end

  // Saturating statistics and first-mismatch capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pass_cnt <= 8'd0;
      r_fail_cnt <= 8'd0;
      r_ff_valid <= 1'b0;
      r_ff_sel   <= 4'd0;
      r_ff_y     <= 8'd0;
    end else if (START) begin
      r_pass_cnt <= 8'd0;
      r_fail_cnt <= 8'd0;
      r_ff_valid <= 1'b0;
      r_ff_sel   <= 4'd0;
      r_ff_y     <= 8'd0;
    end else if (w_cmp) begin
      if (w_match) begin
        if (r_pass_cnt != c_cnt_max) r_pass_cnt <= r_pass_cnt + 8'd1;
      end else begin
        if (r_fail_cnt != c_cnt_max) r_fail_cnt <= r_fail_cnt + 8'd1;
        if (!r_ff_valid) begin
          r_ff_valid <= 1'b1;
          r_ff_sel   <= r_pipe[LATENCY-1].sel;
          r_ff_y     <= Y;
        end
      end
    end
  end

  // Statistic outputs
  always_comb begin
    PASS_CNT         = r_pass_cnt;
    FAIL_CNT         = r_fail_cnt;
    FIRST_FAIL_VALID = r_ff_valid;
    FIRST_FAIL_SEL   = r_ff_sel;
    FIRST_FAIL_Y     = r_ff_y;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_result_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_checker
// Description : Scoreboard bench for alu_result_checker at three parameter
//               points (LATENCY/N_OPS = 1/16, 3/16, 1/255).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_checker;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] y;
    bit         pass;
  } rec_t;

  logic       clk;
  logic       rst;
  logic [7:0] a, b;
  logic       cin;
  logic [3:0] sel;
  logic       st1, st3, st255;
  logic       iv1, iv3, iv255;
  logic [7:0] y1, y3, y255;
  logic       busy1, done1, ffv1;
  logic       busy3, done3, ffv3;
  logic       busy255, done255, ffv255;
  logic [7:0] pc1, fc1, ffy1, pc3, fc3, ffy3, pc255, fc255, ffy255;
  logic [3:0] ffs1, ffs3, ffs255;
  logic [7:0] ra, rb, ry;
  logic       rcin;
  logic [3:0] rsel;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  rec_t       q1[$], q3[$], q255[$];
  logic [7:0] plan1[int], plan3[int], plan255[int];

  alu_result_checker #(.LATENCY(1), .N_OPS(16)) u_d1 (
    .CLK(clk), .RST(rst), .START(st1), .ISSUE_VALID(iv1), .A(a), .B(b), .CIN(cin), .SEL(sel),
    .Y(y1), .BUSY(busy1), .DONE(done1), .PASS_CNT(pc1), .FAIL_CNT(fc1),
    .FIRST_FAIL_VALID(ffv1), .FIRST_FAIL_SEL(ffs1), .FIRST_FAIL_Y(ffy1));

  alu_result_checker #(.LATENCY(3), .N_OPS(16)) u_d3 (
    .CLK(clk), .RST(rst), .START(st3), .ISSUE_VALID(iv3), .A(a), .B(b), .CIN(cin), .SEL(sel),
    .Y(y3), .BUSY(busy3), .DONE(done3), .PASS_CNT(pc3), .FAIL_CNT(fc3),
    .FIRST_FAIL_VALID(ffv3), .FIRST_FAIL_SEL(ffs3), .FIRST_FAIL_Y(ffy3));

  alu_result_checker #(.LATENCY(1), .N_OPS(255)) u_d255 (
    .CLK(clk), .RST(rst), .START(st255), .ISSUE_VALID(iv255), .A(a), .B(b), .CIN(cin), .SEL(sel),
    .Y(y255), .BUSY(busy255), .DONE(done255), .PASS_CNT(pc255), .FAIL_CNT(fc255),
    .FIRST_FAIL_VALID(ffv255), .FIRST_FAIL_SEL(ffs255), .FIRST_FAIL_Y(ffy255));

  alu_ref_model u_ref (.i_a(ra), .i_b(rb), .i_cin(rcin), .i_sel(rsel), .o_y(ry));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU from the opcode table, using integer arithmetic modulo 256
  function automatic logic [7:0] model(input logic [7:0] a_, input logic [7:0] b_,
                                       input logic c_, input logic [3:0] s_);
    int ia, ib, r;
    ia = int'(a_);
    ib = int'(b_);
    case (s_)
      4'h0: r = ia + ib;
      4'h1: r = ia - ib + 256;
      4'h2: r = ia + 1;
      4'h3: r = ia + 255;
      4'h4: r = ia;
      4'h5: r = ia + ib + (c_ ? 1 : 0);
      4'h6: r = int'(a_ & b_);
      4'h7: r = int'(a_ | b_);
      4'h8: r = int'(a_ ^ b_);
      4'h9: r = 255 - ia;
      4'hA: r = 255 - int'(a_ & b_);
      4'hB: r = 255 - int'(a_ | b_);
      4'hC: r = 255 - int'(a_ ^ b_);
      4'hD: r = ia * 2;
      4'hE: r = ia / 2;
      default: r = ib;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Tally one finished run from its list of issued ops and compare with the DUT
  task automatic judge(input string tag, input rec_t q[$], input logic [7:0] pc,
                       input logic [7:0] fc, input logic ffv, input logic [3:0] ffs,
                       input logic [7:0] ffy);
    int np, nf;
    logic [3:0] es;
    logic [7:0] ey;
    np = 0; nf = 0; es = 4'd0; ey = 8'd0;
    foreach (q[i]) begin
      if (q[i].pass) np++;
      else begin
        if (nf == 0) begin es = q[i].sel; ey = q[i].y; end
        nf++;
      end
    end
    chk({tag, "_pass_cnt"}, 32'(pc), 32'((np > 255) ? 255 : np));
    chk({tag, "_fail_cnt"}, 32'(fc), 32'((nf > 255) ? 255 : nf));
    chk({tag, "_ff_valid"}, 32'(ffv), 32'(nf > 0));
    chk({tag, "_ff_sel"}, 32'(ffs), 32'(es));
    chk({tag, "_ff_y"}, 32'(ffy), 32'(ey));
  endtask

  // Monitor: each time a checker enters DONE, score the ops issued in that run
  initial begin
    logic p1, p3, p255;
    p1 = 1'b0; p3 = 1'b0; p255 = 1'b0;
    forever begin
      @(negedge clk);
      if (done1 && !p1) begin judge("d1", q1, pc1, fc1, ffv1, ffs1, ffy1); q1.delete(); end
      if (done3 && !p3) begin judge("d3", q3, pc3, fc3, ffv3, ffs3, ffy3); q3.delete(); end
      if (done255 && !p255) begin
        judge("d255", q255, pc255, fc255, ffv255, ffs255, ffy255); q255.delete();
      end
      p1 = done1; p3 = done3; p255 = done255;
    end
  end

  // Present the scheduled Y values for the coming edge, then clock once
  task automatic tick();
    y1   = plan1.exists(cyc)   ? plan1[cyc]   : 8'($urandom);
    y3   = plan3.exists(cyc)   ? plan3[cyc]   : 8'($urandom);
    y255 = plan255.exists(cyc) ? plan255[cyc] : 8'($urandom);
    if (plan1.exists(cyc))   plan1.delete(cyc);
    if (plan3.exists(cyc))   plan3.delete(cyc);
    if (plan255.exists(cyc)) plan255.delete(cyc);
    @(posedge clk);
    cyc++;
    #1;
    st1 = 0; st3 = 0; st255 = 0;
    iv1 = 0; iv3 = 0; iv255 = 0;
  endtask

  task automatic issue(input int d, input logic [7:0] a_, input logic [7:0] b_, input logic c_,
                       input logic [3:0] s_, input bit bad, input logic [7:0] ybad);
    logic [7:0] e, yv;
    e  = model(a_, b_, c_, s_);
    yv = bad ? ybad : e;
    a = a_; b = b_; cin = c_; sel = s_;
    case (d)
      1: begin iv1 = 1; plan1[cyc + 1] = yv; q1.push_back('{sel: s_, y: yv, pass: (yv == e)}); end
      3: begin iv3 = 1; plan3[cyc + 3] = yv; q3.push_back('{sel: s_, y: yv, pass: (yv == e)}); end
      default: begin
        iv255 = 1; plan255[cyc + 1] = yv; q255.push_back('{sel: s_, y: yv, pass: (yv == e)});
      end
    endcase
    tick();
  endtask

  // Raw issue pulse that the checker is expected to ignore
  task automatic stray(input int d);
    a = 8'($urandom); b = 8'($urandom); sel = 4'($urandom); cin = 1'($urandom);
    if (d == 1) iv1 = 1;
    tick();
  endtask

  task automatic start(input int d);
    case (d)
      1: st1 = 1;
      3: st3 = 1;
      default: st255 = 1;
    endcase
    tick();
    case (d)
      1: chk("d1_busy_after_start", 32'(busy1), 32'd1);
      3: chk("d3_busy_after_start", 32'(busy3), 32'd1);
      default: chk("d255_busy_after_start", 32'(busy255), 32'd1);
    endcase
  endtask

  function automatic logic dn(input int d);
    case (d)
      1: return done1;
      3: return done3;
      default: return done255;
    endcase
  endfunction

  task automatic wait_done(input int d, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (dn(d)) break;
      tick();
    end
    chk($sformatf("done_within_budget_d%0d", d), 32'(dn(d)), 32'd1);
    tick();
  endtask

  task automatic chk_zero_d1(input string tag);
    chk({tag, "_busy"}, 32'(busy1), 32'd0);
    chk({tag, "_done"}, 32'(done1), 32'd0);
    chk({tag, "_pass"}, 32'(pc1), 32'd0);
    chk({tag, "_fail"}, 32'(fc1), 32'd0);
    chk({tag, "_ffv"}, 32'(ffv1), 32'd0);
    chk({tag, "_ffs"}, 32'(ffs1), 32'd0);
    chk({tag, "_ffy"}, 32'(ffy1), 32'd0);
  endtask

  task automatic sel_stream(input bit corrupt6);
    for (int s = 0; s < 16; s++) begin
      issue(1, 8'h93, 8'hA7, (s == 5), 4'(s), corrupt6 && (s == 6), 8'h00);
    end
  endtask

  initial begin
    logic [7:0] xa, xb, e;
    logic [3:0] xs;
    logic       xc;
    int         last_edge, done_edge;
    logic [7:0] exp_tab [6];
    logic [3:0] sel_tab [6];

    rst = 1; st1 = 0; st3 = 0; st255 = 0; iv1 = 0; iv3 = 0; iv255 = 0;
    a = 0; b = 0; cin = 0; sel = 0; y1 = 0; y3 = 0; y255 = 0;
    ra = 8'h93; rb = 8'hA7; rcin = 0; rsel = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_d1("reset");
    rst = 0;

    // Reference spot values for A=0x93, B=0xA7
    sel_tab = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h8};
    exp_tab = '{8'h3A, 8'hEC, 8'h3B, 8'h83, 8'hB7, 8'h34};
    for (int i = 0; i < 6; i++) begin
      rsel = sel_tab[i];
      rcin = (sel_tab[i] == 4'h5);
      #1;
      chk($sformatf("ref_sel%0h", sel_tab[i]), 32'(ry), 32'(exp_tab[i]));
    end

    // Clean SEL 0..F stream, then the same stream with SEL6 forced to 0x00
    start(1); sel_stream(0); wait_done(1, 10);
    start(1); sel_stream(1); wait_done(1, 10);

    // LATENCY=3 with one-cycle gaps; DONE four edges after the last issue
    start(3);
    for (int s = 0; s < 16; s++) begin
      issue(3, 8'($urandom), 8'($urandom), 1'($urandom), 4'(s), 0, 8'h00);
      if (s < 15) tick();
    end
    last_edge = cyc - 1;
    done_edge = -1;
    for (int i = 0; i < 20 && done_edge < 0; i++) begin
      tick();
      if (done3) done_edge = cyc - 1;
    end
    chk("d3_done_latency", 32'(done_edge - last_edge), 32'd4);
    tick();

    // Restart mid-run, then a random run with random corruption
    start(1);
    for (int i = 0; i < 3; i++) issue(1, 8'($urandom), 8'($urandom), 0, 4'($urandom), 1, 8'h00);
    q1.delete();
    start(1);
    for (int i = 0; i < 16; i++) begin
      xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom); xs = 4'($urandom);
      e = model(xa, xb, xc, xs);
      issue(1, xa, xb, xc, xs, ($urandom_range(3) == 0), e ^ 8'(1 + $urandom_range(254)));
    end
    wait_done(1, 10);

    // Asynchronous reset after five ops, one of them mismatching
    start(1);
    for (int i = 0; i < 5; i++) begin
      xa = 8'($urandom); xb = 8'($urandom);
      issue(1, xa, xb, 0, (i == 2) ? 4'h7 : 4'h0, (i == 2), model(xa, xb, 0, 4'h7) ^ 8'h55);
    end
    #2 rst = 1;
    #1 chk_zero_d1("midrun_reset");
    q1.delete();
    plan1.delete();
    tick();
    rst = 0;
    start(1); sel_stream(0); wait_done(1, 10);

    // Issue pulses past op 16, in DONE, and in IDLE are ignored
    start(1); sel_stream(0);
    for (int i = 0; i < 3; i++) stray(1);
    wait_done(1, 10);
    for (int i = 0; i < 3; i++) stray(1);
    chk("done_stray_pass", 32'(pc1), 32'd16);
    chk("done_stray_fail", 32'(fc1), 32'd0);
    chk("done_stray_done", 32'(done1), 32'd1);
    rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) stray(1);
    chk("idle_stray_pass", 32'(pc1), 32'd0);
    chk("idle_stray_busy", 32'(busy1), 32'd0);

    // 255 ops, every Y wrong
    start(255);
    for (int i = 0; i < 255; i++) begin
      xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom); xs = 4'($urandom);
      issue(255, xa, xb, xc, xs, 1, model(xa, xb, xc, xs) + 8'd1);
    end
    wait_done(255, 10);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
